// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-box tables, rcon and FSM encodings.
package aes_pkg;

    localparam int unsigned BLK_W  = 128;
    localparam int unsigned RND_W  = 4;
    localparam int unsigned TBL_W  = 2048;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Multiply by x modulo 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Generic GF(2^8) multiply; only used while elaborating the tables.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // S-box affine transform applied to a multiplicative inverse.
    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Walks x = 3^k and y = 3^-k together (0xf6 is the inverse of 3), so
    // each step yields one S-box pair without any inversion search.
    function automatic logic [TBL_W-1:0] gen_sbox(input logic inv);
        logic [TBL_W-1:0] t;
        logic [7:0]       x, y, s;
        t = '0;
        if (inv) t[{8'h63, 3'b000} +: 8] = 8'h00;
        else     t[{8'h00, 3'b000} +: 8] = 8'h63;
        x = 8'h01;
        y = 8'h01;
        for (int k = 0; k < 255; k++) begin
            s = affine(y);
            if (inv) t[{s, 3'b000} +: 8] = x;
            else     t[{x, 3'b000} +: 8] = s;
            x = x ^ xtime(x);
            y = gf_mul(y, 8'hf6);
        end
        return t;
    endfunction

    localparam logic [TBL_W-1:0] SBOX_TBL     = gen_sbox(1'b0);
    localparam logic [TBL_W-1:0] INV_SBOX_TBL = gen_sbox(1'b1);

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    // Round constant for the key schedule step that produces round rnd-1.
    function automatic logic [7:0] rcon(input logic [RND_W-1:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse AES round plus one backward key-schedule step.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLK_W-1:0] state_i,
    input  logic [BLK_W-1:0] rk_i,
    input  logic [RND_W-1:0] rnd_i,
    output logic [BLK_W-1:0] state_c,
    output logic [BLK_W-1:0] rk_c
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot;

    logic [7:0] st_b  [16];
    logic [7:0] sub_b [16];
    logic [7:0] t_b   [16];
    logic [7:0] mc_b  [16];

    logic [BLK_W-1:0] t_vec;
    logic [BLK_W-1:0] mc_vec;

    // Backward key schedule: recover the previous round key from rk_i.
    assign w0  = rk_i[127:96];
    assign w1  = rk_i[95:64];
    assign w2  = rk_i[63:32];
    assign w3  = rk_i[31:0];
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign p0  = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                    ^ {rcon(rnd_i), 24'h000000};
    assign rk_c = {p0, p1, p2, p3};

    // InvShiftRows moves row r right by r columns, then InvSubBytes and AddRoundKey.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int SRC = (i % 4) + 4 * ((((i / 4) - (i % 4)) + 4) % 4);
        assign st_b[i]  = state_i[8*(15-i) +: 8];
        assign sub_b[i] = inv_sbox(st_b[SRC]);
        assign t_b[i]   = sub_b[i] ^ rk_c[8*(15-i) +: 8];
        assign t_vec[8*(15-i) +: 8]  = t_b[i];
        assign mc_vec[8*(15-i) +: 8] = mc_b[i];
    end

    // InvMixColumns per column with the 0e/0b/0d/09 circulant.
    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mc_b[4*c+0] = mul0e(t_b[4*c]) ^ mul0b(t_b[4*c+1]) ^ mul0d(t_b[4*c+2]) ^ mul09(t_b[4*c+3]);
        assign mc_b[4*c+1] = mul09(t_b[4*c]) ^ mul0e(t_b[4*c+1]) ^ mul0b(t_b[4*c+2]) ^ mul0d(t_b[4*c+3]);
        assign mc_b[4*c+2] = mul0d(t_b[4*c]) ^ mul09(t_b[4*c+1]) ^ mul0e(t_b[4*c+2]) ^ mul0b(t_b[4*c+3]);
        assign mc_b[4*c+3] = mul0b(t_b[4*c]) ^ mul0d(t_b[4*c+1]) ^ mul09(t_b[4*c+2]) ^ mul0e(t_b[4*c+3]);
    end

    // The last round skips InvMixColumns.
    assign state_c = (rnd_i > RND_W'(1)) ? mc_vec : t_vec;

endmodule

// File: rtl/aes_tiny_inv.sv
// Iterative AES-128 decryptor: one inverse round per clock, key schedule run backwards.
module aes_tiny_inv
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] din,
    input  logic [BLK_W-1:0] key,
    output logic [BLK_W-1:0] dout,
    output logic [BLK_W-1:0] kout,
    output logic             busy,
    output logic             done
);

    logic [1:0]       fsm_q,   fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [BLK_W-1:0] rk_q,    rk_d;
    logic [RND_W-1:0] rnd_q,   rnd_d;
    logic [BLK_W-1:0] dout_q,  dout_d;
    logic [BLK_W-1:0] kout_q,  kout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [BLK_W-1:0] round_state_c;
    logic [BLK_W-1:0] round_rk_c;

    aes_inv_round u_round (
        .state_i (state_q),
        .rk_i    (rk_q),
        .rnd_i   (rnd_q),
        .state_c (round_state_c),
        .rk_c    (round_rk_c)
    );

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rk_q    <= '0;
            rnd_q   <= '0;
            dout_q  <= '0;
            kout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            dout_q  <= dout_d;
            kout_q  <= kout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Accept in IDLE/DONE, iterate in RUN, publish results on the last round.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        dout_d  = dout_q;
        kout_d  = kout_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (fsm_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = din ^ key;
                    rk_d    = key;
                    rnd_d   = LAST_RND;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_state_c;
                rk_d    = round_rk_c;
                rnd_d   = rnd_q - RND_W'(1);
                if (rnd_q == RND_W'(1)) begin
                    dout_d = round_state_c;
                    kout_d = round_rk_c;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    fsm_d  = ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    assign dout = dout_q;
    assign kout = kout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_aes_tiny_inv.sv
// Self-checking bench for aes_tiny_inv against a forward AES-128 reference model.
module tb_aes_tiny_inv;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] din;
    logic [127:0] key;
    logic [127:0] dout;
    logic [127:0] kout;
    logic         busy;
    logic         done;

    int n_vec;
    int n_err;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_RK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_tiny_inv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .key   (key),
        .dout  (dout),
        .kout  (kout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: forward AES-128 ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            r = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox_m[x] = s ^ 8'h63;
        end
    endtask

    task automatic aes_enc(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output logic [127:0] rk10);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s [16];
        logic [7:0]  n [16];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = 32'(k >> (32 * (3 - i)));
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]}
                    ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++)
            s[i] = 8'(pt >> (8 * (15 - i))) ^ 8'(w[i/4] >> (8 * (3 - i % 4)));
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
            for (int i = 0; i < 16; i++) n[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(n[4*c], 8'h02) ^ gmul(n[4*c+1], 8'h03) ^ n[4*c+2] ^ n[4*c+3];
                    s[4*c+1] = n[4*c] ^ gmul(n[4*c+1], 8'h02) ^ gmul(n[4*c+2], 8'h03) ^ n[4*c+3];
                    s[4*c+2] = n[4*c] ^ n[4*c+1] ^ gmul(n[4*c+2], 8'h02) ^ gmul(n[4*c+3], 8'h03);
                    s[4*c+3] = gmul(n[4*c], 8'h03) ^ n[4*c+1] ^ n[4*c+2] ^ gmul(n[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = n[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++)
                s[i] = s[i] ^ 8'(w[4*r + i/4] >> (8 * (3 - i % 4)));
        end
        ct = '0;
        for (int i = 0; i < 16; i++) ct = (ct << 8) | 128'(s[i]);
        rk10 = {w[40], w[41], w[42], w[43]};
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic launch(input logic [127:0] d, input logic [127:0] k);
        din   = d;
        key   = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit busy_ok);
        cyc     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_vec++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_vec++; if (kout !== '0) begin n_err++; $display("FAIL reset_kout: got %h expected 0", kout); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_fips(input logic [127:0] ct, input logic [127:0] rk,
                             input logic [127:0] pt, input logic [127:0] k0, input string nm);
        int cyc;
        bit bok;
        launch(ct, rk);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_done_fall: got %b expected 0", nm, done); end
        wait_done(cyc, bok);
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL %s_latency: got %0d expected 10", nm, cyc); end
        n_vec++; if (!bok) begin n_err++; $display("FAIL %s_busy_window: got gap expected busy high 10 cycles", nm); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_end: got %b expected 0", nm, busy); end
        n_vec++; if (dout !== pt) begin n_err++; $display("FAIL %s_dout: got %h expected %h", nm, dout, pt); end
        n_vec++; if (kout !== k0) begin n_err++; $display("FAIL %s_kout: got %h expected %h", nm, kout, k0); end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        launch(C1_CT, C1_RK);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (cyc == 3) begin
                din   = {$urandom, $urandom, $urandom, $urandom};
                key   = {$urandom, $urandom, $urandom, $urandom};
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL ignore_latency: got %0d expected 10", cyc); end
        n_vec++; if (dout !== C1_PT) begin n_err++; $display("FAIL ignore_dout: got %h expected %h", dout, C1_PT); end
        n_vec++; if (kout !== C1_KEY) begin n_err++; $display("FAIL ignore_kout: got %h expected %h", kout, C1_KEY); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL done_hold: got %b expected 1", done); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int low;
        din   = C1_CT;
        key   = C1_RK;
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_vec++; if (cyc != 10) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 10", cyc); end
        n_vec++; if (dout !== C1_PT) begin n_err++; $display("FAIL b2b_first_dout: got %h expected %h", dout, C1_PT); end
        din = B_CT;
        key = B_RK;
        @(posedge clk); #1;
        low = 0;
        while (done !== 1'b1 && low < 40) begin
            low++;
            if (low == 5) begin
                n_vec++; if (dout !== C1_PT || kout !== C1_KEY) begin
                    n_err++; $display("FAIL b2b_hold_old: got %h/%h expected %h/%h", dout, kout, C1_PT, C1_KEY);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++; if (low != 10) begin n_err++; $display("FAIL b2b_done_low: got %0d expected 10", low); end
        n_vec++; if (dout !== B_PT) begin n_err++; $display("FAIL b2b_second_dout: got %h expected %h", dout, B_PT); end
        n_vec++; if (kout !== B_KEY) begin n_err++; $display("FAIL b2b_second_kout: got %h expected %h", kout, B_KEY); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        bit bok;
        launch(C1_CT, C1_RK);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: busy=%b done=%b expected 0/0", busy, done);
        end
        n_vec++; if (dout !== '0 || kout !== '0) begin
            n_err++; $display("FAIL midrst_data: got %h/%h expected 0/0", dout, kout);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || dout !== '0) begin
            n_err++; $display("FAIL midrst_no_partial: busy=%b done=%b dout=%h expected 0/0/0", busy, done, dout);
        end
        launch(B_CT, B_RK);
        wait_done(cyc, bok);
        n_vec++; if (cyc != 10 || !bok) begin n_err++; $display("FAIL midrst_rerun_timing: got %0d cycles busy_ok=%b expected 10/1", cyc, bok); end
        n_vec++; if (dout !== B_PT || kout !== B_KEY) begin
            n_err++; $display("FAIL midrst_rerun_result: got %h/%h expected %h/%h", dout, kout, B_PT, B_KEY);
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] pt, k, ct, rk10;
        int cyc;
        bit bok;
        for (int n = 0; n < 16; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            aes_enc(pt, k, ct, rk10);
            launch(ct, rk10);
            wait_done(cyc, bok);
            n_vec++; if (cyc != 10) begin n_err++; $display("FAIL rt%0d_latency: got %0d expected 10", n, cyc); end
            n_vec++; if (dout !== pt) begin n_err++; $display("FAIL rt%0d_dout: got %h expected %h", n, dout, pt); end
            n_vec++; if (kout !== k) begin n_err++; $display("FAIL rt%0d_kout: got %h expected %h", n, kout, k); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        key   = '0;
        build_sbox();
        repeat (2) begin @(posedge clk); #1; end
        test_reset();
        test_fips(C1_CT, C1_RK, C1_PT, C1_KEY, "c1");
        test_fips(B_CT, B_RK, B_PT, B_KEY, "b");
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_run();
        test_round_trip();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_tiny_inv.md
# aes_tiny_inv

Iterative AES-128 decryption core, the inverse counterpart of `aes_tiny`. It takes a ciphertext block and the final (round-10) round key, and runs one inverse round per clock. The inverse key schedule is computed on the fly, so no key-expansion RAM is needed. It sits beside `aes_tiny` in the on-chip-sensor target, so the same harness can check encrypt/decrypt round trips.

## Interface
- No parameters; block and key width fixed at 128.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to decrypt; sampled only while idle.
- `din` in 128: ciphertext; byte 0 at [127:120]; sampled with `start`.
- `key` in 128: round-10 round key (words w40..w43, w40 at [127:96]); sampled with `start`.
- `dout` out 128: plaintext; valid while `done`=1.
- `kout` out 128: recovered cipher key (round-0 key); valid while `done`=1.
- `busy` out 1: high while a block is in flight.
- `done` out 1: high from completion until the next accepted `start` or reset.

## Operation
- States:
  - IDLE: after reset.
  - RUN: rounds in progress.
  - DONE: result held.
- Accept: `start`=1 in IDLE or DONE at edge N.
  - `state <= din ^ key`, `rk <= key`, `rnd <= 10`.
  - `busy <= 1`, `done <= 0`, go to RUN.
- Each RUN edge:
  - `rk' = inv_ks(rk, rcon[rnd])`, `t = InvSubBytes(InvShiftRows(state)) ^ rk'`.
  - If `rnd` > 1: `state <= InvMixColumns(t)`.
  - If `rnd` = 1: `state <= t` (final round, no InvMixColumns), then `dout <= t`, `kout <= rk'`, `busy <= 0`, `done <= 1`, go to DONE.
  - `rk <= rk'`, `rnd <= rnd-1`.
- `inv_ks` on words w0..w3 returns p0..p3:
  - `p3 = w3^w2`, `p2 = w2^w1`, `p1 = w1^w0`.
  - `p0 = w0 ^ SubWord(RotWord(p3)) ^ {rcon,24'h0}`.
  - `rcon[1..10]` = 01,02,04,08,10,20,40,80,1b,36.
- `start` while in RUN is ignored: no queueing, and `din`/`key` changes have no effect.
- `start` in DONE restarts: `done` falls on the accepting edge, and `dout`/`kout` keep their old values until the new block completes.
- Arithmetic is GF(2^8) with polynomial 0x11b.
- InvMixColumns coefficients are 0e,0b,0d,09, built from the xtime chain with no multipliers.

## Timing
- Reset values: `busy`=0, `done`=0, `dout`=0, `kout`=0, state=IDLE, internal state/rk/`rnd`=0.
- Latency: `start` accepted at edge N, `done`=1 after edge N+10, so 11 cycles from start to result.
- Throughput: one block per 11 cycles when `start` is reissued on the first DONE cycle.
- `busy`=1 exactly after edges N through N+9.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted mid-RUN: all outputs clear asynchronously, and the block returns to IDLE with no partial result.
- `start` held high continuously: a block is accepted in IDLE and again on every DONE cycle (back-to-back operation).

## Structure
- Shared package `aes_pkg` holds:
  - forward S-box function (needed by the key schedule),
  - inverse S-box table,
  - `rcon` function,
  - `xtime` and GF multiply-by-{09,0b,0d,0e} functions,
  - state-encoding constants.
- One natural sub-module: `aes_inv_round`, purely combinational. It takes state, rk and rnd, and returns the next state and rk'. It is instantiated once.
- Estimated size is about 250 RTL lines total.

## Test plan
- FIPS-197 C.1: `key`=13111d7fe3944a17f307a78b4d2b30c5, `din`=69c4e0d86a7b0430d8cdb78070b4c55a, `start` 1 cycle -> 11 cycles later `done`=1, `dout`=00112233445566778899aabbccddeeff, `kout`=000102030405060708090a0b0c0d0e0f.
- FIPS-197 B: `key`=d014f9a8c9ee2589e13f0cc8b6630ca6, `din`=3925841d02dc09fbdc118597196a0b32 -> `dout`=3243f6a8885a308d313198a2e0370734, `kout`=2b7e151628aed2a6abf7158809cf4f3c.
- Busy-ignore: start the C.1 vector, then pulse `start` with garbage `din`/`key` at cycle 4 -> C.1 result unchanged, `done` still at cycle 11.
- Back-to-back: hold `start`=1 and switch vectors on the DONE cycle -> the C.1 result, then the B result 11 cycles later; `done` low for exactly 10 cycles between them.
- Reset mid-run: assert `rst` at cycle 5 -> `busy`/`done`/`dout`/`kout` = 0 immediately; rerunning the vector after release gives the correct result.
- Round trip with `aes_tiny`: encrypt 16 random PT/key pairs, feed CT plus the final round key -> `dout`=PT and `kout`=key for every pair.
